// File: rtl/fetch_defs.sv
// -----------------------------------------------------------------------------
// fetch_defs
// Shared definitions for the fetch front end.
//   fetch_state_t    : fetch sequencer states (IDLE, REQ, WAIT, OUT)
//   SEL_SEQ          : next-PC mux select for PC+4
//   SEL_REDIRECT     : next-PC mux select for the execute redirect target
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
// -----------------------------------------------------------------------------
package fetch_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } fetch_state_t;

   localparam logic [1:0]  SEL_SEQ          = 2'b00;
   localparam logic [1:0]  SEL_REDIRECT     = 2'b01;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles the redirect input, the instruction-memory request/response channel
// and the decode-side instruction handshake of the fetch unit.
//   master : the fetch unit (drives mem request, inst outputs, next_pc_sel)
//   slave  : the surrounding core / memory (drives redirect, stall, mem resp)
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if #(
   parameter int XLEN = 32
);

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            stall;
   logic            mem_req_valid;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_req_ready;
   logic            mem_resp_valid;
   logic [31:0]     mem_resp_data;
   logic            inst_valid;
   logic [31:0]     inst;
   logic [XLEN-1:0] inst_pc;
   logic [1:0]      next_pc_sel;

   modport master (
      input  redirect_valid, redirect_pc, stall,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output mem_req_valid, mem_req_addr,
      output inst_valid, inst, inst_pc, next_pc_sel
   );

   modport slave (
      output redirect_valid, redirect_pc, stall,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  mem_req_valid, mem_req_addr,
      input  inst_valid, inst, inst_pc, next_pc_sel
   );

endinterface

// File: rtl/mux2to1.sv
// -----------------------------------------------------------------------------
// mux2to1
// Generic N-bit two-input multiplexer.
//   sel : 0 selects in0, 1 selects in1
//   in0 : first data input
//   in1 : second data input
//   out : selected data
// -----------------------------------------------------------------------------
module mux2to1 #(
   parameter int N = 32
) (
   input  logic         sel,
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   output logic [N-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Issues one memory request per instruction, presents the returned word to
// decode with a valid/stall handshake and discards fetches made stale by an
// execute redirect.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_pc_unit_if.master
//             redirect_valid/redirect_pc  execute control-flow change
//             stall                       decode back-pressure
//             mem_req_*                   instruction-memory request (addr = PC)
//             mem_resp_*                  instruction-memory response
//             inst_valid/inst/inst_pc     instruction presented to decode
//             next_pc_sel                 select driven to the next-PC mux
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_defs::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_pc_unit_if.master   bus
);

   fetch_state_t    state;
   logic            kill;
   logic [XLEN-1:0] pc;
   logic            req_vld;
   logic            out_vld;
   logic [31:0]     inst_q;
   logic [XLEN-1:0] inst_pc_q;

   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_tgt;
   logic [XLEN-1:0] pc_next;
   logic [1:0]      sel;
   logic            unused_redirect_lsb;

   // Natural modulo-2^XLEN wrap: 32'hFFFF_FFFC + 4 becomes 0.
   assign pc_plus4     = pc + XLEN'(4);
   assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

   // A redirect steers the mux in every state except IDLE, even in cycles
   // where the PC does not load, so downstream consumers see it immediately.
   always_comb begin
      sel = SEL_SEQ;
      if (bus.redirect_valid && (state != ST_IDLE)) begin
         sel = SEL_REDIRECT;
      end
   end

   mux2to1 #(
      .N (XLEN)
   ) u_next_pc_mux (
      .sel (sel[0]),
      .in0 (pc_plus4),
      .in1 (redirect_tgt),
      .out (pc_next)
   );

   // The PC only ever loads pc_next: on a redirect the mux carries the target,
   // on an accepted unkilled response (no redirect) it carries PC+4.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         kill      <= 1'b0;
         pc        <= RESET_PC;
         req_vld   <= 1'b0;
         out_vld   <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state   <= ST_REQ;
               req_vld <= 1'b1;
            end

            ST_REQ: begin
               if (bus.redirect_valid) begin
                  pc <= pc_next;
               end
               if (bus.mem_req_ready) begin
                  state   <= ST_WAIT;
                  req_vld <= 1'b0;
                  // The accepted request was for the old PC; its word is stale.
                  kill    <= bus.redirect_valid;
               end
            end

            ST_WAIT: begin
               if (bus.mem_resp_valid) begin
                  if (kill || bus.redirect_valid) begin
                     kill    <= 1'b0;
                     state   <= ST_REQ;
                     req_vld <= 1'b1;
                     if (bus.redirect_valid) begin
                        pc <= pc_next;
                     end
                  end else begin
                     inst_q    <= bus.mem_resp_data;
                     inst_pc_q <= pc;
                     pc        <= pc_next;
                     state     <= ST_OUT;
                     out_vld   <= 1'b1;
                  end
               end else if (bus.redirect_valid) begin
                  // Response still outstanding: remember to drop it.
                  kill <= 1'b1;
                  pc   <= pc_next;
               end
            end

            ST_OUT: begin
               if (bus.redirect_valid) begin
                  pc      <= pc_next;
                  out_vld <= 1'b0;
                  state   <= ST_REQ;
                  req_vld <= 1'b1;
               end else if (!bus.stall) begin
                  out_vld <= 1'b0;
                  state   <= ST_REQ;
                  req_vld <= 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req_valid = req_vld;
   assign bus.mem_req_addr  = pc;
   assign bus.inst_valid    = out_vld;
   assign bus.inst          = inst_q;
   assign bus.inst_pc       = inst_pc_q;
   assign bus.next_pc_sel   = sel;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Directed self-checking bench for fetch_pc_unit. A second instance with a
// reset PC of 32'hFFFF_FFFC exercises PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   fetch_pc_unit_if #(.XLEN(32)) bus ();
   fetch_pc_unit_if #(.XLEN(32)) bus_w ();

   fetch_pc_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_1000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   fetch_pc_unit #(
      .XLEN     (32),
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n                = 1'b0;
      bus.redirect_valid   = 1'b1;
      bus.redirect_pc      = 32'h0000_7000;
      bus.stall            = 1'b0;
      bus.mem_req_ready    = 1'b0;
      bus.mem_resp_valid   = 1'b0;
      bus.mem_resp_data    = 32'h0;
      bus_w.redirect_valid = 1'b0;
      bus_w.redirect_pc    = 32'h0;
      bus_w.stall          = 1'b0;
      bus_w.mem_req_ready  = 1'b0;
      bus_w.mem_resp_valid = 1'b0;
      bus_w.mem_resp_data  = 32'h0;
      tick();
      tick();
      n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b required 0", bus.mem_req_valid); end
      n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b required 0", bus.inst_valid); end
      n_cmp++; if (bus.inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h required 00000000", bus.inst); end
      n_cmp++; if (bus.inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h required 00000000", bus.inst_pc); end
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL rst_pc: got %h required 00001000", bus.mem_req_addr); end
      n_cmp++; if (bus.next_pc_sel !== 2'b00) begin n_err++; $display("FAIL rst_sel: got %b required 00", bus.next_pc_sel); end
      rst_n = 1'b1;
      #1;
      // Still IDLE: a redirect must not steer the mux.
      n_cmp++; if (bus.next_pc_sel !== 2'b00) begin n_err++; $display("FAIL idle_sel: got %b required 00", bus.next_pc_sel); end
      bus.redirect_valid = 1'b0;
      tick();
      n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %b required 1", bus.mem_req_valid); end
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL first_req_addr: got %h required 00001000", bus.mem_req_addr); end
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      logic [31:0] d;
      bus.mem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h0000_1000 + 32'(4 * i);
         d = 32'hC0DE_0000 + 32'(i);
         n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL seq_req_phase[%0d]: got req=%b iv=%b required req=1 iv=0", i, bus.mem_req_valid, bus.inst_valid); end
         n_cmp++; if (bus.mem_req_addr !== a) begin n_err++; $display("FAIL seq_addr[%0d]: got %h required %h", i, bus.mem_req_addr, a); end
         tick();
         n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL seq_wait_phase[%0d]: got req=%b iv=%b required req=0 iv=0", i, bus.mem_req_valid, bus.inst_valid); end
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = d;
         tick();
         bus.mem_resp_valid = 1'b0;
         n_cmp++; if (bus.inst_valid !== 1'b1 || bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL seq_out_phase[%0d]: got iv=%b req=%b required iv=1 req=0", i, bus.inst_valid, bus.mem_req_valid); end
         n_cmp++; if (bus.inst !== d) begin n_err++; $display("FAIL seq_inst[%0d]: got %h required %h", i, bus.inst, d); end
         n_cmp++; if (bus.inst_pc !== a) begin n_err++; $display("FAIL seq_inst_pc[%0d]: got %h required %h", i, bus.inst_pc, a); end
         tick();
      end
   endtask

   task automatic test_stall();
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_100C) begin n_err++; $display("FAIL stall_start_addr: got %h required 0000100c", bus.mem_req_addr); end
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h5A5A_0001;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.stall          = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.inst_valid !== 1'b1 || bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_hold_vld[%0d]: got iv=%b req=%b required iv=1 req=0", i, bus.inst_valid, bus.mem_req_valid); end
         n_cmp++; if (bus.inst !== 32'h5A5A_0001 || bus.inst_pc !== 32'h0000_100C) begin n_err++; $display("FAIL stall_hold_data[%0d]: got %h@%h required 5a5a0001@0000100c", i, bus.inst, bus.inst_pc); end
      end
      bus.stall = 1'b0;
      tick();
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume_vld: got iv=%b req=%b required iv=0 req=1", bus.inst_valid, bus.mem_req_valid); end
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_1010) begin n_err++; $display("FAIL stall_resume_addr: got %h required 00001010", bus.mem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_2002;
      #1;
      n_cmp++; if (bus.next_pc_sel !== 2'b01) begin n_err++; $display("FAIL rw_sel: got %b required 01", bus.next_pc_sel); end
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      n_cmp++; if (bus.next_pc_sel !== 2'b00) begin n_err++; $display("FAIL rw_sel_clear: got %b required 00", bus.next_pc_sel); end
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_wait1: got iv=%b req=%b required iv=0 req=0", bus.inst_valid, bus.mem_req_valid); end
      tick();
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_wait2: got iv=%b req=%b required iv=0 req=0", bus.inst_valid, bus.mem_req_valid); end
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hDEAD_0001;
      tick();
      bus.mem_resp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rw_drop: got iv=%b req=%b required iv=0 req=1", bus.inst_valid, bus.mem_req_valid); end
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_2000) begin n_err++; $display("FAIL rw_target_addr: got %h required 00002000", bus.mem_req_addr); end
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h600D_2000;
      tick();
      bus.mem_resp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h600D_2000 || bus.inst_pc !== 32'h0000_2000) begin n_err++; $display("FAIL rw_refetch: got iv=%b %h@%h required iv=1 600d2000@00002000", bus.inst_valid, bus.inst, bus.inst_pc); end
      tick();
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_2004) begin n_err++; $display("FAIL rw_next_addr: got %h required 00002004", bus.mem_req_addr); end
   endtask

   task automatic test_simultaneous();
      // Redirect coincident with the request handshake.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_3000;
      #1;
      n_cmp++; if (bus.next_pc_sel !== 2'b01) begin n_err++; $display("FAIL sim_req_sel: got %b required 01", bus.next_pc_sel); end
      tick();
      bus.redirect_valid = 1'b0;
      n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0000_3000) begin n_err++; $display("FAIL sim_req_pc: got req=%b %h required req=0 00003000", bus.mem_req_valid, bus.mem_req_addr); end
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hBAD0_2004;
      tick();
      bus.mem_resp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_3000) begin n_err++; $display("FAIL sim_req_drop: got iv=%b req=%b %h required iv=0 req=1 00003000", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr); end
      // Redirect coincident with the response arrival.
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hBAD0_3000;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_4008;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_4008) begin n_err++; $display("FAIL sim_resp_drop: got iv=%b req=%b %h required iv=0 req=1 00004008", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr); end
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h600D_4008;
      tick();
      bus.mem_resp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h600D_4008 || bus.inst_pc !== 32'h0000_4008) begin n_err++; $display("FAIL sim_refetch: got iv=%b %h@%h required iv=1 600d4008@00004008", bus.inst_valid, bus.inst, bus.inst_pc); end
   endtask

   task automatic test_redirect_priority();
      // In OUT with stall held: the redirect still wins.
      bus.stall          = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_5001;
      tick();
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL prio_vld: got iv=%b req=%b required iv=0 req=1", bus.inst_valid, bus.mem_req_valid); end
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_5000) begin n_err++; $display("FAIL prio_addr: got %h required 00005000", bus.mem_req_addr); end
   endtask

   task automatic test_reset_mid();
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.mem_req_addr !== 32'h0000_1000 || bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_async: got req=%b iv=%b %h required req=0 iv=0 00001000", bus.mem_req_valid, bus.inst_valid, bus.mem_req_addr); end
      tick();
      bus.mem_req_ready  = 1'b0;
      rst_n              = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hBAD0_5000;
      tick();
      n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.inst_valid !== 1'b0 || bus.mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL mid_idle_ignore: got req=%b iv=%b %h required req=1 iv=0 00001000", bus.mem_req_valid, bus.inst_valid, bus.mem_req_addr); end
      tick();
      n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.inst_valid !== 1'b0 || bus.mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL mid_req_ignore: got req=%b iv=%b %h required req=1 iv=0 00001000", bus.mem_req_valid, bus.inst_valid, bus.mem_req_addr); end
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_ready  = 1'b1;
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h600D_1000;
      tick();
      bus.mem_resp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h600D_1000 || bus.inst_pc !== 32'h0000_1000) begin n_err++; $display("FAIL mid_first_fetch: got iv=%b %h@%h required iv=1 600d1000@00001000", bus.inst_valid, bus.inst, bus.inst_pc); end
   endtask

   task automatic test_wrap();
      n_cmp++; if (bus_w.mem_req_valid !== 1'b1 || bus_w.mem_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first: got req=%b %h required req=1 fffffffc", bus_w.mem_req_valid, bus_w.mem_req_addr); end
      bus_w.mem_req_ready = 1'b1;
      tick();
      bus_w.mem_resp_valid = 1'b1;
      bus_w.mem_resp_data  = 32'h0000_FFFC;
      tick();
      bus_w.mem_resp_valid = 1'b0;
      n_cmp++; if (bus_w.inst_valid !== 1'b1 || bus_w.inst_pc !== 32'hFFFF_FFFC || bus_w.inst !== 32'h0000_FFFC) begin n_err++; $display("FAIL wrap_out: got iv=%b %h@%h required iv=1 0000fffc@fffffffc", bus_w.inst_valid, bus_w.inst, bus_w.inst_pc); end
      tick();
      n_cmp++; if (bus_w.mem_req_valid !== 1'b1 || bus_w.mem_req_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_second: got req=%b %h required req=1 00000000", bus_w.mem_req_valid, bus_w.mem_req_addr); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_simultaneous();
      test_redirect_priority();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch sequencer for the core's front end. Holds the architectural fetch PC, drives the select of the downstream next-PC `mux2to1` (sequential vs. redirect), and issues one instruction-memory request at a time. Returned instruction words are presented to decode with a valid/stall handshake. Stale fetches are discarded when execute signals a redirect.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_PC`, 32'h0000_1000: PC loaded on reset; bits [1:0] must be zero.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `redirect_valid` in 1: execute requests a control-flow change this cycle.
- `redirect_pc` in XLEN: redirect target; bits [1:0] ignored and treated as 0.
- `stall` in 1: decode cannot accept the presented instruction.
- `mem_req_valid` out 1: fetch request valid.
- `mem_req_addr` out XLEN: fetch address, always equal to the current PC.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: instruction word returned.
- `mem_resp_data` in 32: instruction word.
- `inst_valid` out 1: instruction presented to decode.
- `inst` out 32: presented instruction.
- `inst_pc` out XLEN: PC of the presented instruction.
- `next_pc_sel` out 2: select for the next-PC `mux2to1`. 2'b00 selects PC+4 (in0); 2'b01 selects `redirect_pc` (in1). 2'b1x is never driven.

## Operation
- States: IDLE, REQ, WAIT, OUT, plus a 1-bit `kill` flag.
- Reset values:
  - state IDLE; `kill`=0; PC=`RESET_PC`.
  - `mem_req_valid`=0; `inst_valid`=0; `inst`=0; `inst_pc`=0; `next_pc_sel`=2'b00.
- IDLE: unconditionally moves to REQ on the first clock after reset release. Responses are ignored.
- REQ:
  - `mem_req_valid`=1.
  - Handshake (`mem_req_ready`=1) moves to WAIT.
  - If `redirect_valid` is high in the same cycle, PC loads the redirect target. `kill` is set only when the handshake also completes that cycle.
- WAIT:
  - On `mem_resp_valid` with `kill`=0 and no redirect: capture `inst`←data and `inst_pc`←PC, then PC←PC+4 and go to OUT.
  - On a response with `kill`=1, or with a coincident redirect: drop the word, clear `kill`, go to REQ.
  - Redirect without a response: set `kill`; PC←target.
- OUT:
  - `inst_valid`=1.
  - `stall`=0: transfer completes; go to REQ.
  - `stall`=1: hold `inst`/`inst_pc` stable.
  - Redirect has priority over stall: PC←target, `inst_valid` drops the next cycle, go to REQ.
- `next_pc_sel` = 2'b01 whenever `redirect_valid` and state ≠ IDLE, else 2'b00 (combinational).
- PC loads the mux output only on:
  - a redirect, or
  - an accepted, unkilled response.
- PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC → 0).
- `mem_resp_valid` outside WAIT is ignored, including responses still in flight when a reset is applied mid-request.

## Timing
- Request accepted at cycle t, response at t+k (k≥1). Then `inst_valid` is high at t+k+1.
- Minimum issue interval is 3 cycles (REQ, WAIT, OUT) with k=1 and no stall.
- `mem_req_valid`, `mem_req_addr`, `inst*` are registered/state-decoded; only `next_pc_sel` is combinational from inputs.
- Redirect in cycle c: `mem_req_addr`=target no later than cycle c+1 (REQ), or after the stale response is dropped (WAIT).
- Asynchronous reset forces the reset values immediately, regardless of state.

## Structure
- Shared package `fetch_defs`:
  - state encodings;
  - `SEL_SEQ`=2'b00, `SEL_REDIRECT`=2'b01;
  - default `RESET_PC`.
- Single sub-module: instantiate the existing `mux2to1` (N=`XLEN`) for next-PC selection, with in0=PC+4 and in1=`{redirect_pc[XLEN-1:2],2'b00}`.
- The PC register and FSM live in this block.

## Test plan
- Reset sequential fetch: release reset, `mem_req_ready`=1, k=1, no stall → `mem_req_addr` 0x1000, 0x1004, 0x1008; `inst_pc` matches; `inst_valid` high every third cycle.
- Stall hold: `stall` high for 4 cycles in OUT → `inst`/`inst_pc` stable, no new request, then resume at next PC.
- Redirect in WAIT: redirect to 0x2002 while waiting, k=3 → response dropped, `inst_valid` stays 0, next `mem_req_addr`=0x2000, `next_pc_sel`=01 during redirect.
- Simultaneous events: redirect with request handshake, and separately redirect with response arrival → neither old-PC word is ever presented; next fetch at target.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC → second fetch address 0x0000_0000.
- Reset mid-operation: assert `rst_n` low in WAIT, pulse `mem_resp_valid` after release → word ignored, first fetch at `RESET_PC`.
